// File: rtl/wrr_packet_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
// The arbiter (slave) samples requests/tails/weights and drives the grant signals.
interface wrr_packet_arbiter_if #(
  parameter int INPORT   = 5,
  parameter int WEIGHT_W = 3
);
  localparam int IDW = $clog2(INPORT);

  logic                       off_sig;
  logic [0:INPORT-1]          requests;
  logic [0:INPORT-1]          tails;
  logic [INPORT*WEIGHT_W-1:0] weights;
  logic [0:INPORT-1]          grants_out;
  logic                       grant_valid;
  logic [IDW-1:0]             grant_id;
  logic                       locked;

  modport slave (
    input  off_sig, requests, tails, weights,
    output grants_out, grant_valid, grant_id, locked
  );

  modport master (
    output off_sig, requests, tails, weights,
    input  grants_out, grant_valid, grant_id, locked
  );
endinterface

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin switch-allocation arbiter with packet locking.
// Define WRR_PKT_LOCK_EN to honour tails; otherwise every transfer is a tail (flit-level WRR).
module wrr_packet_arbiter #(
  parameter int INPORT   = 5,
  parameter int WEIGHT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  wrr_packet_arbiter_if.slave bus
);
  localparam int IDW = $clog2(INPORT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              r_state, w_state_n;
  logic [IDW-1:0]      r_owner, w_owner_n;
  logic [IDW-1:0]      r_ptr, w_ptr_n, w_ptr_cand;
  logic [WEIGHT_W-1:0] r_credit, w_credit_n, w_sel_credit;
  logic [IDW-1:0]      w_win, w_sel, w_idx;
  logic [IDW:0]        w_sum;
  logic                w_found, w_gv, w_tail;
  logic [0:INPORT-1]   w_grants;
  logic [WEIGHT_W-1:0] w_wt [INPORT];

  for (genvar p = 0; p < INPORT; p++) begin : g_wt
    assign w_wt[p] = bus.weights[p*WEIGHT_W +: WEIGHT_W];
  end

  // First requester at or after r_ptr, wrapping modulo INPORT.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < INPORT; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(INPORT)) w_sum = w_sum - (IDW+1)'(INPORT);
      w_idx = w_sum[IDW-1:0];
      if (!w_found && bus.requests[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

`ifdef WRR_PKT_LOCK_EN
  assign w_tail = bus.tails[w_sel];
`else
  assign w_tail = 1'b1;
`endif

  always_comb begin
    w_sel        = r_owner;
    w_sel_credit = r_credit;
    w_ptr_cand   = r_ptr;
    w_gv         = 1'b0;
    w_grants     = '0;
    w_state_n    = r_state;
    w_owner_n    = r_owner;
    w_credit_n   = r_credit;
    w_ptr_n      = r_ptr;

    case (r_state)
      IDLE: begin
        if ((r_credit != '0) && bus.requests[r_owner]) begin
          w_gv = 1'b1;
        end else if (w_found) begin
          w_gv         = 1'b1;
          w_sel        = w_win;
          w_sel_credit = (w_wt[w_win] == '0) ? WEIGHT_W'(1) : w_wt[w_win];
          w_ptr_cand   = (w_win == IDW'(INPORT-1)) ? '0 : w_win + 1'b1;
        end
      end
      LOCKED: w_gv = bus.requests[r_owner];
      default: w_gv = 1'b0;
    endcase

    if (bus.off_sig) w_gv = 1'b0;

    // Credit is loaded on a fresh win and consumed only when the tail transfers.
    if (w_gv) begin
      w_grants[w_sel] = 1'b1;
      w_owner_n       = w_sel;
      w_ptr_n         = w_ptr_cand;
      if (w_tail) begin
        w_credit_n = w_sel_credit - 1'b1;
        w_state_n  = IDLE;
      end else begin
        w_credit_n = w_sel_credit;
        w_state_n  = LOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_credit <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_owner  <= w_owner_n;
      r_credit <= w_credit_n;
      r_ptr    <= w_ptr_n;
    end
  end

  assign bus.grants_out  = w_grants;
  assign bus.grant_valid = w_gv;
  assign bus.grant_id    = w_gv ? w_sel : '0;
`ifdef WRR_PKT_LOCK_EN
  assign bus.locked      = (r_state == LOCKED);
`else
  assign bus.locked      = 1'b0;
`endif

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed bench for wrr_packet_arbiter (INPORT=4, WEIGHT_W=3) with a packet-level
// reference model checked every cycle plus literal per-step expectations.
module tb_wrr_packet_arbiter;
  localparam int N  = 4;
  localparam int WW = 3;
`ifdef WRR_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  wrr_packet_arbiter_if #(.INPORT(N), .WEIGHT_W(WW)) bus ();

  wrr_packet_arbiter #(.INPORT(N), .WEIGHT_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: who holds the output, packets left, where rotation starts, mid-packet flag
  int m_owner  = 0;
  int m_credit = 0;
  int m_ptr    = 0;
  bit m_inpkt  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wt(input int p);
    int w;
    w = int'((bus.weights >> (WW * p)) & 12'h7);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [N*WW-1:0] wts(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic model_grant(output bit v, output int id, output bit fresh);
    v = 1'b0; id = 0; fresh = 1'b0;
    if (bus.off_sig) return;
    if (m_inpkt) begin
      v  = bus.requests[m_owner];
      id = v ? m_owner : 0;
      return;
    end
    if (m_credit > 0 && bus.requests[m_owner]) begin
      v = 1'b1; id = m_owner;
      return;
    end
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (bus.requests[p]) begin
        v = 1'b1; id = p; fresh = 1'b1;
        return;
      end
    end
  endtask

  always @(posedge clk) begin
    bit v, fr, is_tail;
    int id, c;
    if (rst) begin
      m_owner  <= 0;
      m_credit <= 0;
      m_ptr    <= 0;
      m_inpkt  <= 1'b0;
    end else begin
      model_grant(v, id, fr);
      if (v) begin
        c = fr ? wt(id) : m_credit;
        if (fr) begin
          m_owner <= id;
          m_ptr   <= (id + 1) % N;
        end
        is_tail = LOCK_EN ? bus.tails[id] : 1'b1;
        m_credit <= is_tail ? c - 1 : c;
        m_inpkt  <= !is_tail;
      end
    end
  end

  always @(negedge clk) begin
    bit v, fr;
    int id;
    logic [0:N-1] e;
    if (!rst) begin
      model_grant(v, id, fr);
      e = '0;
      if (v) e[id] = 1'b1;
      check("model.grants_out", 32'(bus.grants_out), 32'(e));
      check("model.grant_valid", 32'(bus.grant_valid), 32'(v));
      check("model.grant_id", 32'(bus.grant_id), 32'(id));
      check("model.locked", 32'(bus.locked), 32'(m_inpkt));
    end
  end

  task automatic step(input logic [0:N-1] req, input logic [0:N-1] tl, input logic off,
                      input logic r, input int ev, input int eid, input int elk,
                      input string nm);
    @(posedge clk);
    #1;
    bus.requests = req;
    bus.tails    = tl;
    bus.off_sig  = off;
    rst          = r;
    @(negedge clk);
    if (ev  >= 0) check({nm, ".valid"},  32'(bus.grant_valid), 32'(ev));
    if (eid >= 0) check({nm, ".id"},     32'(bus.grant_id),    32'(eid));
    if (elk >= 0) check({nm, ".locked"}, 32'(bus.locked),      32'(elk));
  endtask

  int exp_wrr[7] = '{0, 0, 1, 2, 3, 0, 0};
  int exp_w0[5]  = '{1, 2, 3, 0, 1};

  initial begin
    rst          = 1'b1;
    bus.off_sig  = 1'b0;
    bus.requests = '0;
    bus.tails    = '0;
    bus.weights  = wts(1, 1, 1, 1);

    step(4'b0000, 4'b0000, 1'b0, 1'b1, -1, -1, 0, "reset");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 0, 0, "idle");

    for (int i = 0; i < 4; i++)
      step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, i, 0, "rr");

    bus.weights = wts(2, 1, 1, 1);
    for (int i = 0; i < 7; i++)
      step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, exp_wrr[i], 0, "wrr");
    bus.weights = wts(1, 1, 1, 1);

    // 3-flit packet on port 1 with a bubble after the head
    step(4'b1111, 4'b0000, 1'b0, 1'b0, 1, 1, 0, "pkt_head");
    step(4'b1011, 4'b0000, 1'b0, 1'b0, LOCK_EN ? 0 : 1, LOCK_EN ? 0 : 2, LOCK_EN, "pkt_bubble");
    step(4'b1111, 4'b0000, 1'b0, 1'b0, 1, LOCK_EN ? 1 : 3, LOCK_EN, "pkt_body");
    step(4'b1111, 4'b0100, 1'b0, 1'b0, 1, LOCK_EN ? 1 : 0, LOCK_EN, "pkt_tail");
    step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, LOCK_EN ? 2 : 1, 0, "pkt_next");

    // Stall mid-packet; a tail offered under off_sig must not be consumed
    step(4'b0100, 4'b0000, 1'b0, 1'b0, 1, 1, 0, "off_head");
    step(4'b1111, 4'b0000, 1'b1, 1'b0, 0, 0, LOCK_EN, "off_1");
    step(4'b1111, 4'b1111, 1'b1, 1'b0, 0, 0, LOCK_EN, "off_2");
    step(4'b1111, 4'b0100, 1'b0, 1'b0, 1, LOCK_EN ? 1 : 2, LOCK_EN, "off_resume");
    step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, LOCK_EN ? 2 : 3, 0, "off_next");

    // Reset while locked on port 2
    step(4'b0010, 4'b0000, 1'b0, 1'b0, 1, 2, 0, "rst_head");
    step(4'b1111, 4'b0000, 1'b0, 1'b1, -1, -1, LOCK_EN, "rst_locked");
    step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, 0, 0, "rst_after");

    // Zero weights behave as one
    bus.weights = wts(0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, exp_w0[i], 0, "w0");

    // Leftover credit is dropped when the owner stops requesting
    bus.weights = wts(1, 1, 3, 1);
    step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, 2, 0, "disc_win");
    step(4'b1101, 4'b1111, 1'b0, 1'b0, 1, 3, 0, "disc_skip");
    step(4'b1111, 4'b1111, 1'b0, 1'b0, 1, 0, 0, "disc_rot");

    step(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 0, 0, "final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wrr_packet_arbiter.md
# wrr_packet_arbiter

Parametrised weighted round-robin arbiter with packet locking, the next generation of the router's switch-allocation arbiter. It selects one of `INPORT` requesting input ports per cycle, holds the grant on the winner until that port's tail flit passes, and lets each port win up to `weights[p]` consecutive packets before priority rotates. It sits in front of each router output port crossbar mux and keeps the `off_sig` stall semantics of the existing arbiter.

## Interface
- `INPORT`, 5, number of requesting input ports (≥2)
- `WEIGHT_W`, 3, width of each per-port weight field
- `clk`  input  1  clock
- `rst`  input  1  synchronous, active-high reset
- `off_sig`  input  1  stall: forces zero grants and freezes all state
- `requests`  input  [0:INPORT-1]  per-port request, one flit available
- `tails`  input  [0:INPORT-1]  per-port tail marker, qualified by `requests`
- `weights`  input  [INPORT*WEIGHT_W-1:0]  static weights; port p at bits [p*WEIGHT_W +: WEIGHT_W]; value 0 treated as 1
- `grants_out`  output  [0:INPORT-1]  one-hot or zero grant
- `grant_valid`  output  1  OR of `grants_out`
- `grant_id`  output  [$clog2(INPORT)-1:0]  index of granted port; 0 when `grant_valid`=0
- `locked`  output  1  registered; a packet is in progress on `owner`

## Operation
- State: `state` ∈ {IDLE, LOCKED}; `owner` (port index); `credit` (WEIGHT_W bits, remaining packets for `owner`); `ptr` (rotation start index).
- A flit transfers on a cycle where `grant_valid`=1 and `off_sig`=0.
- IDLE arbitration, in this order:
  - If `credit`>0 and `requests[owner]`=1, grant `owner`.
  - Otherwise search ports `ptr`, `ptr`+1, …, wrapping modulo INPORT, and grant the first requester w. Then `owner`←w, `credit`←max(weights[w],1), `ptr`←(w+1) mod INPORT. The credit is loaded before the decrement below.
- IDLE transfer:
  - If `tails[owner]`=1 (single-flit packet), `credit` decrements and the state stays IDLE.
  - Otherwise the state goes to LOCKED.
- LOCKED:
  - `grants_out` is one-hot `owner` when `requests[owner]`=1, otherwise zero. No other port is ever granted, even when `owner` has a bubble.
  - A transfer with `tails[owner]`=1 decrements `credit` and returns the state to IDLE.
- When `credit` reaches 0, the next IDLE cycle always uses the rotation search. The former owner is eligible again only when the search wraps round to it.
- Unused `credit` is discarded when `owner` is not requesting in IDLE: the arbiter rotates and reloads the credit.
- `off_sig`=1:
  - `grants_out`=0, `grant_valid`=0, `grant_id`=0.
  - `state`, `owner`, `credit` and `ptr` hold.
  - `locked` holds.
- `requests` and `tails` of non-granted ports are don't-care. `weights` is sampled only at a credit load.

## Timing
- Grant outputs are combinational from `requests`, `tails`, `off_sig` and the registered state, with zero-cycle latency as in the current arbiter. State updates on the `posedge clk`.
- Reset (synchronous, takes priority over `off_sig`): state IDLE, `owner`=0, `credit`=0, `ptr`=0, `locked`=0.
- After reset, with all requests low: `grants_out`=0, `grant_valid`=0, `grant_id`=0. The first search starts at port 0.
- Reset mid-packet abandons the lock immediately; the next cycle arbitrates from port 0.
- `locked` rises the cycle after a non-tail head transfer. It falls the cycle after the tail transfer.
- A tail arriving in a cycle with `off_sig`=1 is not consumed. The lock persists until the tail transfers.
- Back-to-back packets: when a tail transfers in cycle n, a new grant (same or different port) is issued in cycle n+1. There is no dead cycle.
- `credit` never underflows. A decrement happens only on a transfer, and `credit`≥1 whenever a grant is issued.

## Configuration
- Macro `WRR_PKT_LOCK_EN`.
- Defined: packet locking as described, with `tails` honoured.
- Undefined: `tails` is ignored and every transfer is treated as a tail. LOCKED is never entered and `locked` is tied to 0. The block becomes a flit-level weighted round-robin arbiter where each grant consumes one credit.

## Test plan
Test configuration: INPORT=4, WEIGHT_W=3, all weights 1 unless stated.
- Reset, then `requests`=4'b1111 with all tails 1 for 4 cycles: `grant_id` sequence 0,1,2,3; `locked` stays 0.
- Weights {2,1,1,1}, all ports requesting single-flit packets: grant sequence 0,0,1,2,3,0,0,… repeating.
- Port 1 sends a 3-flit packet while ports 0–3 request:
  - Cycle 0: head, grant_id=1.
  - Cycle 1: `requests[1]`=0, so `grants_out`=0 and `locked`=1.
  - Cycles 2–3: body then tail, both granted to port 1.
  - Cycle 4: grant_id=2.
- Mid-packet `off_sig`=1 for 2 cycles: grants zero, `locked`, `credit` and `owner` unchanged. The packet resumes on port 1 when `off_sig` drops.
- Assert `rst` while LOCKED on port 2: next cycle `locked`=0 and, with `requests`=4'b1111, `grant_id`=0.
- With `WRR_PKT_LOCK_EN` undefined, repeat the 3-flit scenario: port 1 gets one flit, then grants rotate 2,3,0,1. `locked` stays 0.
